// File: rtl/icb_txn_beat_tracker_if.sv
// Observed SA-side ICB command channel, bundled for the beat tracker.
// master drives the command signals; slave is the passive observer.
interface icb_txn_beat_tracker_if #(
   parameter int WIDTH     = 32,
   parameter int ADDR_W    = 32,
   parameter int ICB_LEN_W = 3
);
   localparam int DW = WIDTH / 8;

   logic                 icb_cmd_valid;
   logic                 icb_cmd_ready;
   logic [ADDR_W-1:0]    icb_cmd_addr;
   logic                 icb_cmd_read;
   logic [ICB_LEN_W-1:0] icb_cmd_len;
   logic [WIDTH-1:0]     icb_cmd_wdata;
   logic [DW-1:0]        icb_cmd_wmask;

   modport master (
      output icb_cmd_valid, icb_cmd_ready, icb_cmd_addr, icb_cmd_read,
             icb_cmd_len, icb_cmd_wdata, icb_cmd_wmask
   );

   modport slave (
      input icb_cmd_valid, icb_cmd_ready, icb_cmd_addr, icb_cmd_read,
            icb_cmd_len, icb_cmd_wdata, icb_cmd_wmask
   );
endinterface

// File: rtl/icb_txn_beat_tracker.sv
// Passive ICB cmd monitor: expands bursts into per-beat records behind a FIFO.
// Define ICB_TRK_ADDR_CHK_EN to check write-burst beat addresses (addr_err).
module icb_txn_beat_tracker #(
   parameter int WIDTH      = 32,
   parameter int ADDR_W     = 32,
   parameter int ICB_LEN_W  = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   icb_txn_beat_tracker_if.slave  icb,
   output logic                   txn_valid,
   input  logic                   txn_ready,
   output logic [ADDR_W-1:0]      txn_addr,
   output logic                   txn_read,
   output logic [WIDTH/8-1:0]     txn_wmask,
   output logic [WIDTH-1:0]       txn_wdata,
   output logic                   txn_last,
   output logic                   ovf,
   output logic                   proto_err,
   output logic                   addr_err
);
   localparam int DW    = WIDTH / 8;
   localparam int DW_LG = $clog2(DW);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0]    addr;
      logic                 read;
      logic [ICB_LEN_W-1:0] len;
      logic [DW-1:0]        wmask;
      logic [WIDTH-1:0]     wdata;
      logic                 last;
   } entry_t;

   typedef enum logic {CAP_IDLE, CAP_WBURST} cap_state_t;
   typedef enum logic {EXP_IDLE, EXP_READ}   exp_state_t;

   cap_state_t           cap_state_q, cap_state_d;
   logic [ADDR_W-1:0]    base_q, base_d;
   logic [ICB_LEN_W-1:0] len_q, len_d;
   logic [ICB_LEN_W-1:0] wcnt_q, wcnt_d;
   logic                 proto_err_q, proto_err_d;
   logic                 ovf_q, ovf_d;

   exp_state_t           exp_state_q, exp_state_d;
   logic [ICB_LEN_W-1:0] rd_len_q, rd_len_d;
   logic [ICB_LEN_W-1:0] rd_k_q, rd_k_d;
   logic                 txn_valid_q, txn_valid_d;
   logic [ADDR_W-1:0]    txn_addr_q, txn_addr_d;
   logic                 txn_read_q, txn_read_d;
   logic [DW-1:0]        txn_wmask_q, txn_wmask_d;
   logic [WIDTH-1:0]     txn_wdata_q, txn_wdata_d;
   logic                 txn_last_q, txn_last_d;

   entry_t               mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     mem_cnt_q, mem_cnt_d;

   logic                 hs;
   entry_t               cap_entry;
   logic [ADDR_W-1:0]    aligned;
   logic [ADDR_W-1:0]    beat_addr;
   logic                 beat_addr_bad;
   logic [CNT_W-1:0]     occ;
   logic                 rd_last;
   logic                 slot_done;
   logic                 push_ok;
   logic                 load;
   logic                 from_mem;
   logic                 mem_wr;
   logic [ICB_LEN_W-1:0] rd_k_nxt;
   entry_t               nxt;

   assign hs        = icb.icb_cmd_valid & icb.icb_cmd_ready;
   assign aligned   = icb.icb_cmd_addr & ~ADDR_W'(DW - 1);
   assign beat_addr = base_q + (ADDR_W'(wcnt_q) << DW_LG);

   // Occupancy counts the record slot too, so capacity is FIFO_DEPTH entries overall.
   assign occ       = mem_cnt_q + CNT_W'(txn_valid_q);
   assign rd_last   = (exp_state_q == EXP_IDLE) || (rd_k_q == rd_len_q);
   assign slot_done = txn_valid_q & txn_ready & rd_last;
   assign push_ok   = hs & ((occ != CNT_W'(FIFO_DEPTH)) | slot_done);
   assign rd_k_nxt  = rd_k_q + ICB_LEN_W'(1);

   // Capture side: turn each observed handshake into one FIFO entry
   always_comb begin
      cap_state_d   = cap_state_q;
      base_d        = base_q;
      len_d         = len_q;
      wcnt_d        = wcnt_q;
      proto_err_d   = proto_err_q;
      ovf_d         = ovf_q | (hs & ~push_ok);
      beat_addr_bad = 1'b0;
      cap_entry     = '0;
      if (hs) begin
         if (icb.icb_cmd_read) begin
            cap_entry.addr = aligned;
            cap_entry.read = 1'b1;
            cap_entry.len  = icb.icb_cmd_len;
            cap_state_d    = CAP_IDLE;
            if (cap_state_q == CAP_WBURST) proto_err_d = 1'b1;
         end else if (cap_state_q == CAP_IDLE) begin
            cap_entry.addr  = aligned;
            cap_entry.len   = icb.icb_cmd_len;
            cap_entry.wmask = icb.icb_cmd_wmask;
            cap_entry.wdata = icb.icb_cmd_wdata;
            cap_entry.last  = (icb.icb_cmd_len == '0);
            if (icb.icb_cmd_len != '0) begin
               base_d      = aligned;
               len_d       = icb.icb_cmd_len;
               wcnt_d      = ICB_LEN_W'(1);
               cap_state_d = CAP_WBURST;
            end
         end else begin
            // Beats keep counting even when dropped, so later addresses stay right
            cap_entry.addr  = beat_addr;
            cap_entry.wmask = icb.icb_cmd_wmask;
            cap_entry.wdata = icb.icb_cmd_wdata;
            cap_entry.last  = (wcnt_q == len_q);
            wcnt_d          = wcnt_q + ICB_LEN_W'(1);
            beat_addr_bad   = (icb.icb_cmd_addr != beat_addr);
            if (wcnt_q == len_q) cap_state_d = CAP_IDLE;
         end
      end
   end

   // Expander side: refill the record slot from the FIFO head, or straight from capture
   always_comb begin
      exp_state_d = exp_state_q;
      rd_len_d    = rd_len_q;
      rd_k_d      = rd_k_q;
      txn_valid_d = txn_valid_q;
      txn_addr_d  = txn_addr_q;
      txn_read_d  = txn_read_q;
      txn_wmask_d = txn_wmask_q;
      txn_wdata_d = txn_wdata_q;
      txn_last_d  = txn_last_q;
      load        = 1'b0;
      from_mem    = 1'b0;
      nxt         = cap_entry;
      if (~txn_valid_q | slot_done) begin
         if (mem_cnt_q != '0) begin
            load     = 1'b1;
            from_mem = 1'b1;
            nxt      = mem[rd_ptr_q];
         end else if (push_ok) begin
            load = 1'b1;
         end
      end
      mem_wr = push_ok & ~(load & ~from_mem);

      if (load) begin
         txn_valid_d = 1'b1;
         txn_addr_d  = nxt.addr;
         txn_read_d  = nxt.read;
         if (nxt.read) begin
            txn_wmask_d = '0;
            txn_wdata_d = '0;
            txn_last_d  = (nxt.len == '0);
            exp_state_d = EXP_READ;
            rd_len_d    = nxt.len;
            rd_k_d      = '0;
         end else begin
            txn_wmask_d = nxt.wmask;
            txn_wdata_d = nxt.wdata;
            txn_last_d  = nxt.last;
            exp_state_d = EXP_IDLE;
         end
      end else if (slot_done) begin
         txn_valid_d = 1'b0;
         exp_state_d = EXP_IDLE;
      end else if (txn_valid_q & txn_ready) begin
         txn_addr_d = txn_addr_q + ADDR_W'(DW);
         rd_k_d     = rd_k_nxt;
         txn_last_d = (rd_k_nxt == rd_len_q);
      end

      wr_ptr_d  = wr_ptr_q + PTR_W'(mem_wr);
      rd_ptr_d  = rd_ptr_q + PTR_W'(from_mem);
      mem_cnt_d = mem_cnt_q + CNT_W'(mem_wr) - CNT_W'(from_mem);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_state_q <= CAP_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         wcnt_q      <= '0;
         proto_err_q <= 1'b0;
         ovf_q       <= 1'b0;
         exp_state_q <= EXP_IDLE;
         rd_len_q    <= '0;
         rd_k_q      <= '0;
         txn_valid_q <= 1'b0;
         txn_addr_q  <= '0;
         txn_read_q  <= 1'b0;
         txn_wmask_q <= '0;
         txn_wdata_q <= '0;
         txn_last_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
      end else begin
         cap_state_q <= cap_state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         wcnt_q      <= wcnt_d;
         proto_err_q <= proto_err_d;
         ovf_q       <= ovf_d;
         exp_state_q <= exp_state_d;
         rd_len_q    <= rd_len_d;
         rd_k_q      <= rd_k_d;
         txn_valid_q <= txn_valid_d;
         txn_addr_q  <= txn_addr_d;
         txn_read_q  <= txn_read_d;
         txn_wmask_q <= txn_wmask_d;
         txn_wdata_q <= txn_wdata_d;
         txn_last_q  <= txn_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_cnt_q   <= mem_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) mem[wr_ptr_q] <= cap_entry;
   end

`ifdef ICB_TRK_ADDR_CHK_EN
   logic addr_err_q, addr_err_d;

   always_comb begin
      addr_err_d = addr_err_q;
      if (hs & ~icb.icb_cmd_read & (cap_state_q == CAP_WBURST) & beat_addr_bad) addr_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) addr_err_q <= 1'b0;
      else     addr_err_q <= addr_err_d;
   end

   assign addr_err = addr_err_q;
`else
   logic unused_addr_chk;
   assign unused_addr_chk = beat_addr_bad;
   assign addr_err        = 1'b0;
`endif

   assign txn_valid = txn_valid_q;
   assign txn_addr  = txn_addr_q;
   assign txn_read  = txn_read_q;
   assign txn_wmask = txn_wmask_q;
   assign txn_wdata = txn_wdata_q;
   assign txn_last  = txn_last_q;
   assign ovf       = ovf_q;
   assign proto_err = proto_err_q;
endmodule

// File: tb/tb_icb_txn_beat_tracker.sv
// Scoreboard bench for icb_txn_beat_tracker: directed cmd traffic, queued expected records.
`timescale 1ns/1ps
module tb_icb_txn_beat_tracker;
   localparam int WIDTH      = 32;
   localparam int ADDR_W     = 32;
   localparam int ICB_LEN_W  = 3;
   localparam int FIFO_DEPTH = 8;

   typedef struct {
      logic [31:0] addr;
      logic        read;
      logic [3:0]  wmask;
      logic [31:0] wdata;
      logic        last;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        txn_valid;
   logic        txn_ready;
   logic [31:0] txn_addr;
   logic        txn_read;
   logic [3:0]  txn_wmask;
   logic [31:0] txn_wdata;
   logic        txn_last;
   logic        ovf;
   logic        proto_err;
   logic        addr_err;

   rec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   icb_txn_beat_tracker_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ICB_LEN_W(ICB_LEN_W)) icb ();

   icb_txn_beat_tracker #(
      .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ICB_LEN_W(ICB_LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .icb(icb),
      .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_addr(txn_addr),
      .txn_read(txn_read), .txn_wmask(txn_wmask), .txn_wdata(txn_wdata),
      .txn_last(txn_last), .ovf(ovf), .proto_err(proto_err), .addr_err(addr_err)
   );

   task automatic expect_rec(input logic [31:0] a, input logic r, input logic [3:0] m,
                             input logic [31:0] d, input logic l);
      rec_t e;
      e.addr = a; e.read = r; e.wmask = m; e.wdata = d; e.last = l;
      exp_q.push_back(e);
   endtask

   task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   // One cmd handshake, held for exactly one clock edge.
   task automatic beat(input logic [31:0] a, input logic r, input logic [2:0] len,
                       input logic [3:0] m, input logic [31:0] d);
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_ready = 1'b1;
      icb.icb_cmd_addr  = a;
      icb.icb_cmd_read  = r;
      icb.icb_cmd_len   = len;
      icb.icb_cmd_wmask = m;
      icb.icb_cmd_wdata = d;
      @(posedge clk); #1;
      icb.icb_cmd_valid = 1'b0;
      icb.icb_cmd_ready = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || txn_valid) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || txn_valid) begin
         errors++;
         $display("FAIL drain_%s: %0d records still expected, txn_valid=%0b, expected 0 and 0",
                  name, exp_q.size(), txn_valid);
      end
   endtask

   // Monitor: every presented record is compared with the scoreboard head.
   always @(negedge clk) begin : mon
      rec_t e;
      if (!rst && txn_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_record: got addr=0x%0h rd=%0b, expected no record",
                     txn_addr, txn_read);
         end else begin
            e = exp_q[0];
            if (txn_addr !== e.addr || txn_read !== e.read || txn_wmask !== e.wmask ||
                txn_wdata !== e.wdata || txn_last !== e.last) begin
               errors++;
               $display("FAIL %s: got addr=0x%0h rd=%0b mask=0x%0h data=0x%0h last=%0b, expected addr=0x%0h rd=%0b mask=0x%0h data=0x%0h last=%0b",
                        txn_ready ? "record" : "hold", txn_addr, txn_read, txn_wmask,
                        txn_wdata, txn_last, e.addr, e.read, e.wmask, e.wdata, e.last);
            end
            if (txn_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      txn_ready = 1'b0;
      icb.icb_cmd_valid = 1'b0;
      icb.icb_cmd_ready = 1'b0;
      icb.icb_cmd_addr  = '0;
      icb.icb_cmd_read  = 1'b0;
      icb.icb_cmd_len   = '0;
      icb.icb_cmd_wmask = '0;
      icb.icb_cmd_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check1("reset_txn_valid", 32'(txn_valid), 32'd0);
      check1("reset_ovf", 32'(ovf), 32'd0);
      check1("reset_proto_err", 32'(proto_err), 32'd0);
      check1("reset_addr_err", 32'(addr_err), 32'd0);

      // Single write; a valid-without-ready cycle must not count
      txn_ready = 1'b1;
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_addr  = 32'h1003;
      @(posedge clk); #1;
      icb.icb_cmd_valid = 1'b0;
      check1("no_hs_no_record", 32'(txn_valid), 32'd0);
      expect_rec(32'h1000, 1'b0, 4'b0101, 32'hA1B2C3D4, 1'b1);
      beat(32'h1003, 1'b0, 3'd0, 4'b0101, 32'hA1B2C3D4);
      check1("single_latency", 32'(txn_valid), 32'd1);
      wait_drain("single");

      // 4-beat write burst; len driven only meaningfully on the first beat
      expect_rec(32'h200, 1'b0, 4'hF, 32'h0000_0A00, 1'b0);
      expect_rec(32'h204, 1'b0, 4'h3, 32'h0000_0A01, 1'b0);
      expect_rec(32'h208, 1'b0, 4'hC, 32'h0000_0A02, 1'b0);
      expect_rec(32'h20C, 1'b0, 4'h1, 32'h0000_0A03, 1'b1);
      beat(32'h200, 1'b0, 3'd3, 4'hF, 32'h0000_0A00);
      beat(32'h204, 1'b0, 3'd0, 4'h3, 32'h0000_0A01);
      beat(32'h208, 1'b0, 3'd0, 4'hC, 32'h0000_0A02);
      beat(32'h20C, 1'b0, 3'd0, 4'h1, 32'h0000_0A03);
      wait_drain("wburst");

      // Read burst with a one-cycle stall on the second record
      expect_rec(32'h40, 1'b1, 4'h0, 32'h0, 1'b0);
      expect_rec(32'h44, 1'b1, 4'h0, 32'h0, 1'b0);
      expect_rec(32'h48, 1'b1, 4'h0, 32'h0, 1'b1);
      beat(32'h40, 1'b1, 3'd2, 4'hF, 32'hDEADBEEF);
      @(posedge clk); #1;
      txn_ready = 1'b0;
      @(posedge clk); #1;
      txn_ready = 1'b1;
      wait_drain("rburst");
      check1("proto_err_clean", 32'(proto_err), 32'd0);

      // Overflow: nine singles into an eight-deep tracker with the consumer stalled
      txn_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) expect_rec(32'h500 + 32'(4 * i), 1'b0, 4'hF, 32'h100 + 32'(i), 1'b1);
         beat(32'h500 + 32'(4 * i), 1'b0, 3'd0, 4'hF, 32'h100 + 32'(i));
         if (i == 7) check1("ovf_at_capacity", 32'(ovf), 32'd0);
      end
      check1("ovf_set", 32'(ovf), 32'd1);
      txn_ready = 1'b1;
      wait_drain("ovf");

      // Read interrupts a write burst that starts just below the top address
      expect_rec(32'hFFFF_FFF8, 1'b0, 4'hF, 32'h1111_1111, 1'b0);
      expect_rec(32'hFFFF_FFFC, 1'b0, 4'hF, 32'h2222_2222, 1'b0);
      expect_rec(32'h80, 1'b1, 4'h0, 32'h0, 1'b0);
      expect_rec(32'h84, 1'b1, 4'h0, 32'h0, 1'b1);
      beat(32'hFFFF_FFF8, 1'b0, 3'd3, 4'hF, 32'h1111_1111);
      beat(32'hFFFF_FFFC, 1'b0, 3'd0, 4'hF, 32'h2222_2222);
      check1("proto_err_before_read", 32'(proto_err), 32'd0);
      beat(32'h80, 1'b1, 3'd1, 4'hF, 32'h3333_3333);
      check1("proto_err_set", 32'(proto_err), 32'd1);
      wait_drain("proto");

      expect_rec(32'hFFFF_FFFC, 1'b0, 4'h6, 32'h4444_4444, 1'b0);
      expect_rec(32'h0000_0000, 1'b0, 4'h9, 32'h5555_5555, 1'b1);
      beat(32'hFFFF_FFFC, 1'b0, 3'd1, 4'h6, 32'h4444_4444);
      beat(32'h0000_0000, 1'b0, 3'd0, 4'h9, 32'h5555_5555);
      wait_drain("wrap");

      // Reset in the middle of a stalled write burst
      txn_ready = 1'b0;
      expect_rec(32'h300, 1'b0, 4'hF, 32'h3000, 1'b0);
      expect_rec(32'h304, 1'b0, 4'hF, 32'h3001, 1'b0);
      expect_rec(32'h308, 1'b0, 4'hF, 32'h3002, 1'b0);
      beat(32'h300, 1'b0, 3'd3, 4'hF, 32'h3000);
      beat(32'h304, 1'b0, 3'd0, 4'hF, 32'h3001);
      beat(32'h308, 1'b0, 3'd0, 4'hF, 32'h3002);
      check1("ovf_sticky", 32'(ovf), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      check1("midrst_txn_valid", 32'(txn_valid), 32'd0);
      check1("midrst_ovf", 32'(ovf), 32'd0);
      check1("midrst_proto_err", 32'(proto_err), 32'd0);
      check1("midrst_addr_err", 32'(addr_err), 32'd0);
      txn_ready = 1'b1;
      expect_rec(32'h700, 1'b0, 4'h9, 32'h77, 1'b1);
      beat(32'h700, 1'b0, 3'd0, 4'h9, 32'h77);
      check1("post_rst_latency", 32'(txn_valid), 32'd1);
      wait_drain("post_rst");

      // Third beat carries a wrong address; the record keeps the computed one
      expect_rec(32'h200, 1'b0, 4'hF, 32'hB0, 1'b0);
      expect_rec(32'h204, 1'b0, 4'hF, 32'hB1, 1'b0);
      expect_rec(32'h208, 1'b0, 4'hF, 32'hB2, 1'b0);
      expect_rec(32'h20C, 1'b0, 4'hF, 32'hB3, 1'b1);
      beat(32'h200, 1'b0, 3'd3, 4'hF, 32'hB0);
      beat(32'h204, 1'b0, 3'd0, 4'hF, 32'hB1);
      check1("addr_err_good_beats", 32'(addr_err), 32'd0);
      beat(32'h210, 1'b0, 3'd0, 4'hF, 32'hB2);
      beat(32'h20C, 1'b0, 3'd0, 4'hF, 32'hB3);
`ifdef ICB_TRK_ADDR_CHK_EN
      check1("addr_err_set", 32'(addr_err), 32'd1);
`else
      check1("addr_err_tied", 32'(addr_err), 32'd0);
`endif
      wait_drain("addr_chk");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
